// File: rtl/prog_loader_if.sv
// Signal bundle between prog_loader and its environment: load request, byte
// stream handshake, program-memory write port and status/checksum outputs.
interface prog_loader_if;
  logic       start;
  logic [5:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_rst;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] checksum;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, mem_wr, mem_addr, mem_data, cpu_rst, busy, done, err, checksum
  );

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, mem_wr, mem_addr, mem_data, cpu_rst, busy, done, err, checksum
  );
endinterface

// File: rtl/prog_loader.sv
// Loads a 1..32 byte program into a 32x8 CPU memory, zero-fills the rest,
// then releases the CPU from reset. Idle upstream for TIMEOUT cycles is an error.
module prog_loader #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus
);

  localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [5:0]        len_r, len_s;
  logic [5:0]        byte_cnt_r, byte_cnt_s;
  logic [IDLE_W-1:0] idle_cnt_r, idle_cnt_s;
  logic [7:0]        checksum_r, checksum_s;
  logic              accept_s;
  logic              wr_s;
  logic [4:0]        wr_addr_s;
  logic [7:0]        wr_data_s;

  logic              mem_wr_r;
  logic [4:0]        mem_addr_r;
  logic [7:0]        mem_data_r;
  logic              in_ready_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              cpu_rst_r;

  function automatic logic len_legal(input logic [5:0] l);
    return (l != 6'd0) && (l <= 6'd32);
  endfunction

  // Next-state, counter, checksum and memory-write request logic
  always_comb begin
    state_s    = state_r;
    len_s      = len_r;
    byte_cnt_s = byte_cnt_r;
    idle_cnt_s = idle_cnt_r;
    checksum_s = checksum_r;
    wr_s       = 1'b0;
    wr_addr_s  = mem_addr_r;
    wr_data_s  = mem_data_r;
    // in_ready_r is only ever high while in LOAD
    accept_s   = in_ready_r && bus.in_valid;

    case (state_r)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (bus.start) begin
          if (len_legal(bus.len)) begin
            state_s    = ST_LOAD;
            len_s      = bus.len;
            byte_cnt_s = 6'd0;
            idle_cnt_s = {IDLE_W{1'b0}};
            checksum_s = 8'h00;
          end else begin
            state_s = ST_ERR;
          end
        end else begin
          state_s = state_r;
        end
      end

      ST_LOAD: begin
        if (accept_s) begin
          wr_s       = 1'b1;
          wr_addr_s  = byte_cnt_r[4:0];
          wr_data_s  = bus.in_data;
          checksum_s = checksum_r + bus.in_data;
          byte_cnt_s = byte_cnt_r + 6'd1;
          idle_cnt_s = {IDLE_W{1'b0}};
          if ((byte_cnt_r + 6'd1) == len_r) begin
            state_s = (len_r == 6'd32) ? ST_RUN : ST_CLEAR;
          end else begin
            state_s = ST_LOAD;
          end
        end else if (idle_cnt_r == IDLE_LIMIT) begin
          // this idle cycle is the TIMEOUT-th in a row
          state_s = ST_ERR;
        end else begin
          idle_cnt_s = idle_cnt_r + IDLE_W'(1);
        end
      end

      ST_CLEAR: begin
        wr_s       = 1'b1;
        wr_addr_s  = byte_cnt_r[4:0];
        wr_data_s  = 8'h00;
        byte_cnt_s = byte_cnt_r + 6'd1;
        if (byte_cnt_r == 6'd31) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_CLEAR;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, length, counter and checksum registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      len_r      <= 6'd0;
      byte_cnt_r <= 6'd0;
      idle_cnt_r <= {IDLE_W{1'b0}};
      checksum_r <= 8'h00;
    end else begin
      state_r    <= state_s;
      len_r      <= len_s;
      byte_cnt_r <= byte_cnt_s;
      idle_cnt_r <= idle_cnt_s;
      checksum_r <= checksum_s;
    end
  end

  // Registered outputs; cpu_rst stays high on the cycle a restart leaves RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wr_r   <= 1'b0;
      mem_addr_r <= 5'd0;
      mem_data_r <= 8'h00;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      cpu_rst_r  <= 1'b1;
    end else begin
      mem_wr_r   <= wr_s;
      mem_addr_r <= wr_addr_s;
      mem_data_r <= wr_data_s;
      in_ready_r <= (state_s == ST_LOAD);
      busy_r     <= (state_s == ST_LOAD) || (state_s == ST_CLEAR);
      done_r     <= (state_s == ST_RUN);
      err_r      <= (state_s == ST_ERR);
      cpu_rst_r  <= !((state_r == ST_RUN) && (state_s == ST_RUN));
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.mem_wr   = mem_wr_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_data = mem_data_r;
  assign bus.cpu_rst  = cpu_rst_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.checksum = checksum_r;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader (TIMEOUT=4); expected memory
// images and checksums come from a simple array model of a program load.
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst;

  prog_loader_if bus();

  prog_loader #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int         chk_cnt  = 0;
  int         pass_cnt = 0;
  int         cyc      = 0;
  int         last_wr_cyc = -1;
  int         fall_cyc    = -1;
  logic       prev_cpu_rst = 1'b1;
  logic [12:0] wr_q[$];
  logic [7:0]  bytes_a[32];

  // Write/cpu_rst monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.mem_wr === 1'b1) begin
      wr_q.push_back({bus.mem_addr, bus.mem_data});
      last_wr_cyc <= cyc;
    end
    if (prev_cpu_rst === 1'b1 && bus.cpu_rst === 1'b0) fall_cyc <= cyc;
    prev_cpu_rst <= bus.cpu_rst;
    cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", chk_cnt);
    $fatal(1, "watchdog expired");
  end

  // Model: a load of l bytes leaves addr a = byte a for a<l, else 0x00, written in ascending order
  function automatic int first_diff(input logic [5:0] l, input int base);
    logic [7:0] d;
    for (int a = 0; a < 32; a++) begin
      d = (a < int'(l)) ? bytes_a[a] : 8'h00;
      if (base + a >= wr_q.size()) return a;
      if (wr_q[base + a] !== {5'(a), d}) return a;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_sum(input logic [5:0] l);
    int s = 0;
    for (int i = 0; i < int'(l); i++) s += int'(bytes_a[i]);
    return 8'(s % 256);
  endfunction

  task automatic run_load(input logic [5:0] l, input int max_gap, input bit noise,
                          output bit tmo, output bit extra_rdy, output logic rst_after);
    int guard;
    int gap;
    tmo = 1'b0;
    extra_rdy = 1'b0;
    bus.start = 1'b1;
    bus.len   = l;
    @(negedge clk);
    bus.start = 1'b0;
    rst_after = bus.cpu_rst;
    for (int i = 0; i < int'(l); i++) begin
      gap = int'($urandom_range(max_gap, 0));
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = bytes_a[i];
      if (noise && ($urandom_range(3, 0) == 0)) begin
        bus.start = 1'b1;
        bus.len   = 6'($urandom_range(63, 0));
      end
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) tmo = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.in_data = 8'($urandom);
    repeat (2) begin
      if (bus.in_ready !== 1'b0) extra_rdy = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    guard = 0;
    while (bus.done !== 1'b1 && bus.err !== 1'b1 && guard < 80) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 80) tmo = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    #12;
    chk_cnt++;
    if (bus.cpu_rst !== 1'b1) $display("FAIL reset_cpu_rst: got %0b want 1", bus.cpu_rst);
    else pass_cnt++;
    chk_cnt++;
    if (bus.checksum !== 8'h00) $display("FAIL reset_checksum: got %0h want 00", bus.checksum);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.in_ready, bus.mem_wr, bus.mem_addr, bus.mem_data, bus.busy, bus.done, bus.err} !== 18'd0)
      $display("FAIL reset_outputs: got %0h want 0",
               {bus.in_ready, bus.mem_wr, bus.mem_addr, bus.mem_data, bus.busy, bus.done, bus.err});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({bus.cpu_rst, bus.busy, bus.done, bus.err} !== 4'b1000)
      $display("FAIL idle_status: got %b want 1000", {bus.cpu_rst, bus.busy, bus.done, bus.err});
    else pass_cnt++;
  endtask

  task automatic test_directed;
    bit tmo, xr;
    logic ra;
    int base, c0, d;
    bytes_a[0] = 8'hA1; bytes_a[1] = 8'h22; bytes_a[2] = 8'h05;
    base = wr_q.size();
    c0 = cyc;
    run_load(6'd3, 0, 1'b0, tmo, xr, ra);
    chk_cnt++;
    if (tmo !== 1'b0) $display("FAIL dir_timeout: got %0b want 0", tmo); else pass_cnt++;
    chk_cnt++;
    if (wr_q.size() - base !== 32) $display("FAIL dir_wr_count: got %0d want 32", wr_q.size() - base);
    else pass_cnt++;
    d = first_diff(6'd3, base);
    chk_cnt++;
    if (d !== -1) $display("FAIL dir_wr_content: got first bad index %0d want -1", d); else pass_cnt++;
    chk_cnt++;
    if (bus.checksum !== 8'hC8) $display("FAIL dir_checksum: got %0h want c8", bus.checksum); else pass_cnt++;
    chk_cnt++;
    if ({bus.done, bus.cpu_rst, bus.busy} !== 3'b100)
      $display("FAIL dir_run_status: got %b want 100", {bus.done, bus.cpu_rst, bus.busy});
    else pass_cnt++;
    chk_cnt++;
    if (fall_cyc <= c0 || fall_cyc !== last_wr_cyc + 1)
      $display("FAIL dir_cpu_rst_fall: got cycle %0d want %0d", fall_cyc, last_wr_cyc + 1);
    else pass_cnt++;
  endtask

  task automatic test_full_32;
    bit tmo, xr;
    logic ra;
    int base, d;
    for (int i = 0; i < 32; i++) bytes_a[i] = 8'($urandom);
    base = wr_q.size();
    run_load(6'd32, 2, 1'b0, tmo, xr, ra);
    chk_cnt++;
    if (xr !== 1'b0) $display("FAIL full_in_ready_after_last: got %0b want 0", xr); else pass_cnt++;
    chk_cnt++;
    if (wr_q.size() - base !== 32) $display("FAIL full_wr_count: got %0d want 32", wr_q.size() - base);
    else pass_cnt++;
    d = first_diff(6'd32, base);
    chk_cnt++;
    if (d !== -1) $display("FAIL full_wr_content: got first bad index %0d want -1", d); else pass_cnt++;
    chk_cnt++;
    if (bus.checksum !== model_sum(6'd32))
      $display("FAIL full_checksum: got %0h want %0h", bus.checksum, model_sum(6'd32));
    else pass_cnt++;
    chk_cnt++;
    if (bus.done !== 1'b1) $display("FAIL full_done: got %0b want 1", bus.done); else pass_cnt++;
  endtask

  task automatic test_len_limits;
    int base, guard;
    base = wr_q.size();
    bus.start = 1'b1; bus.len = 6'd33;
    @(negedge clk);
    bus.start = 1'b0;
    chk_cnt++;
    if ({bus.err, bus.busy, bus.cpu_rst} !== 3'b101)
      $display("FAIL len33_err: got %b want 101", {bus.err, bus.busy, bus.cpu_rst});
    else pass_cnt++;
    bus.start = 1'b1; bus.len = 6'd0;
    @(negedge clk);
    bus.start = 1'b0;
    chk_cnt++;
    if ({bus.err, bus.busy, bus.done} !== 3'b100)
      $display("FAIL len0_err: got %b want 100", {bus.err, bus.busy, bus.done});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (wr_q.size() != base) $display("FAIL len_err_no_writes: got %0d want 0", wr_q.size() - base);
    else pass_cnt++;
    bus.start = 1'b1; bus.len = 6'd1;
    @(negedge clk);
    bus.start = 1'b0;
    chk_cnt++;
    if ({bus.busy, bus.in_ready, bus.err} !== 3'b110)
      $display("FAIL len1_load: got %b want 110", {bus.busy, bus.in_ready, bus.err});
    else pass_cnt++;
    bus.in_valid = 1'b1; bus.in_data = 8'h3C;
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (bus.done !== 1'b1 && guard < 80) begin
      @(negedge clk);
      guard++;
    end
    chk_cnt++;
    if (bus.done !== 1'b1) $display("FAIL len1_done: got %0b want 1", bus.done); else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout;
    int base;
    base = wr_q.size();
    bus.start = 1'b1; bus.len = 6'd2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (bus.err !== 1'b0) $display("FAIL tmo_early: got err %0b want 0 after 3 idle", bus.err); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({bus.err, bus.in_ready, bus.busy} !== 3'b100)
      $display("FAIL tmo_err: got %b want 100", {bus.err, bus.in_ready, bus.busy});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (wr_q.size() - base !== 1) $display("FAIL tmo_wr_count: got %0d want 1", wr_q.size() - base);
    else pass_cnt++;
    chk_cnt++;
    if (bus.cpu_rst !== 1'b1) $display("FAIL tmo_cpu_rst: got %0b want 1", bus.cpu_rst); else pass_cnt++;
  endtask

  task automatic test_rst_in_clear;
    int base;
    bus.start = 1'b1; bus.len = 6'd1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk_cnt++;
    if ({bus.busy, bus.in_ready, bus.mem_wr} !== 3'b101)
      $display("FAIL clr_active: got %b want 101", {bus.busy, bus.in_ready, bus.mem_wr});
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    base = wr_q.size();
    chk_cnt++;
    if ({bus.cpu_rst, bus.checksum} !== 9'h100)
      $display("FAIL clr_rst_cpu_sum: got %0h want 100", {bus.cpu_rst, bus.checksum});
    else pass_cnt++;
    chk_cnt++;
    if ({bus.in_ready, bus.mem_wr, bus.mem_addr, bus.mem_data, bus.busy, bus.done, bus.err} !== 18'd0)
      $display("FAIL clr_rst_outputs: got %0h want 0",
               {bus.in_ready, bus.mem_wr, bus.mem_addr, bus.mem_data, bus.busy, bus.done, bus.err});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (wr_q.size() != base) $display("FAIL clr_rst_writes: got %0d want 0", wr_q.size() - base);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.busy, bus.done, bus.cpu_rst} !== 3'b001)
      $display("FAIL clr_rst_idle: got %b want 001", {bus.busy, bus.done, bus.cpu_rst});
    else pass_cnt++;
  endtask

  task automatic test_restart;
    bit tmo, xr;
    logic ra;
    int base, c0, d;
    for (int i = 0; i < 32; i++) bytes_a[i] = 8'($urandom);
    run_load(6'd4, 1, 1'b0, tmo, xr, ra);
    chk_cnt++;
    if (bus.cpu_rst !== 1'b0) $display("FAIL rs_pre_run: got cpu_rst %0b want 0", bus.cpu_rst); else pass_cnt++;
    bytes_a[0] = 8'($urandom);
    base = wr_q.size();
    c0 = cyc;
    run_load(6'd1, 0, 1'b0, tmo, xr, ra);
    chk_cnt++;
    if (ra !== 1'b1) $display("FAIL rs_cpu_rst_rise: got %0b want 1", ra); else pass_cnt++;
    d = first_diff(6'd1, base);
    chk_cnt++;
    if (d !== -1 || wr_q.size() - base !== 32)
      $display("FAIL rs_writes: got bad index %0d count %0d want -1 32", d, wr_q.size() - base);
    else pass_cnt++;
    chk_cnt++;
    if (bus.done !== 1'b1 || fall_cyc <= c0 || fall_cyc !== last_wr_cyc + 1)
      $display("FAIL rs_run: got done %0b fall %0d want 1 %0d", bus.done, fall_cyc, last_wr_cyc + 1);
    else pass_cnt++;
  endtask

  task automatic test_random;
    bit tmo, xr;
    logic ra;
    int base, d;
    logic [5:0] l;
    for (int it = 0; it < 8; it++) begin
      l = (it == 0) ? 6'd1 : (it == 1) ? 6'd32 : 6'($urandom_range(32, 1));
      for (int i = 0; i < 32; i++) bytes_a[i] = 8'($urandom);
      base = wr_q.size();
      run_load(l, 2, 1'b1, tmo, xr, ra);
      chk_cnt++;
      if (tmo !== 1'b0 || xr !== 1'b0)
        $display("FAIL rnd%0d_flow: got tmo %0b extra_ready %0b want 0 0", it, tmo, xr);
      else pass_cnt++;
      chk_cnt++;
      if (wr_q.size() - base !== 32)
        $display("FAIL rnd%0d_wr_count: got %0d want 32 (len %0d)", it, wr_q.size() - base, l);
      else pass_cnt++;
      d = first_diff(l, base);
      chk_cnt++;
      if (d !== -1) $display("FAIL rnd%0d_wr_content: got bad index %0d want -1 (len %0d)", it, d, l);
      else pass_cnt++;
      chk_cnt++;
      if (bus.checksum !== model_sum(l))
        $display("FAIL rnd%0d_checksum: got %0h want %0h", it, bus.checksum, model_sum(l));
      else pass_cnt++;
      chk_cnt++;
      if ({bus.done, bus.cpu_rst, bus.err} !== 3'b100)
        $display("FAIL rnd%0d_status: got %b want 100", it, {bus.done, bus.cpu_rst, bus.err});
      else pass_cnt++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.len      = 6'd0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_directed();
    test_full_32();
    test_len_limits();
    test_timeout();
    test_rst_in_clear();
    test_restart();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
